// File: rtl/mem_port_arbiter_pkg.sv
// Shared pipeline constants for the unified-memory port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the arbiter FSM state encoding, the requester/owner encoding and
// the default data width used by the pipeline.
package mem_port_arbiter_pkg;

    localparam int PIPE_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_ME = 1'b1
    } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between fetch (IF) and memory stage (ME).
// Latency: 0 cycles (pure combinational).
// Backpressure: acks only assert while the arbiter is idle; losers keep requesting.
//
// Ports:
//   if_req, me_req   requests from fetch and memory stage
//   streak_full      IF has waited long enough; IF overrides ME priority
//   idle             arbiter can accept a new transaction this cycle
//   grant            some request is accepted this cycle
//   if_ack, me_ack   per-requester accept
//   owner            winner of the arbitration (valid when grant = 1)
module mem_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req,
    input  logic   me_req,
    input  logic   streak_full,
    input  logic   idle,
    output logic   grant,
    output logic   if_ack,
    output logic   me_ack,
    output owner_t owner
);

    logic if_wins;

    always_comb begin
        // ME is the older instruction and normally wins; IF only wins when
        // ME is absent or the starvation guard has saturated.
        if_wins = if_req && (!me_req || streak_full);
        grant   = idle && (if_req || me_req);
        if_ack  = idle && if_wins;
        me_ack  = idle && me_req && !if_wins;
        owner   = if_wins ? OWN_IF : OWN_ME;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported I/D memory between fetch and the memory stage, one transaction in flight.
// Latency: ack in N, mem_req from N+1, zero-wait memory gives if_rvalid/me_done in N+3; next accept N+4.
// Backpressure: requesters hold req/fields until ack; mem_req held until mem_gnt.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   if_req/if_addr/if_ack    fetch read request and accept
//   if_rvalid/if_rdata       fetch response pulse and instruction word
//   if_flush                 kills an outstanding or pending fetch
//   me_req/me_we/me_addr/me_wdata/me_ack   memory-stage load/store request and accept
//   me_done/me_rdata         load data valid / store complete pulse, load data
//   mem_*                    single memory port (req/gnt handshake, rvalid response)
//
// Optional feature: define ARB_STARVE_GUARD_EN to let IF win after MAX_STREAK
// consecutive ME grants made while IF was waiting.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int XLEN       = PIPE_XLEN,
    parameter int ADDR_W     = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              if_flush,
    input  logic              me_req,
    input  logic              me_we,
    input  logic [ADDR_W-1:0] me_addr,
    input  logic [XLEN-1:0]   me_wdata,
    output logic              me_ack,
    output logic              me_done,
    output logic [XLEN-1:0]   me_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_state_t        state;
    owner_t            owner;
    logic              discard;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_we;
    logic [XLEN-1:0]   cap_wdata;

    logic              idle;
    logic              grant;
    logic              streak_full;
    owner_t            pick_owner;
    logic              if_kill;

    assign idle    = (state == ST_IDLE);
    assign if_kill = if_flush && (owner == OWN_IF);

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .me_req      (me_req),
        .streak_full (streak_full),
        .idle        (idle),
        .grant       (grant),
        .if_ack      (if_ack),
        .me_ack      (me_ack),
        .owner       (pick_owner)
    );

`ifdef ARB_STARVE_GUARD_EN
    localparam int                    STREAK_W   = $clog2(MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0]   STREAK_MAX = STREAK_W'(MAX_STREAK);

    logic [STREAK_W-1:0] streak;

    assign streak_full = (streak == STREAK_MAX);

    // Counts ME grants that made a waiting IF lose. Any IF grant, or an idle
    // cycle without IF pending, means IF is not being starved.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak <= '0;
        end else if (idle) begin
            if (!if_req || if_ack) begin
                streak <= '0;
            end else if (me_ack && !streak_full) begin
                streak <= streak + STREAK_W'(1);
            end
        end
    end
`else
    // No counter: strict ME priority, the guard condition is constant false.
    assign streak_full = (MAX_STREAK < 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            owner     <= OWN_IF;
            discard   <= 1'b0;
            cap_addr  <= '0;
            cap_we    <= 1'b0;
            cap_wdata <= '0;
            if_rdata  <= '0;
            me_rdata  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant) begin
                        state   <= ST_REQ;
                        owner   <= pick_owner;
                        discard <= 1'b0;
                        if (pick_owner == OWN_ME) begin
                            cap_addr  <= me_addr;
                            cap_we    <= me_we;
                            cap_wdata <= me_wdata;
                        end else begin
                            cap_addr  <= if_addr;
                            cap_we    <= 1'b0;
                            cap_wdata <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        // Memory already took the access: the response will
                        // come, so it has to be waited for and dropped.
                        state <= ST_WAIT;
                        if (if_kill) begin
                            discard <= 1'b1;
                        end
                    end else if (if_kill) begin
                        state <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (if_kill) begin
                        discard <= 1'b1;
                    end
                    if (mem_rvalid) begin
                        state <= ST_RESP;
                        if (owner == OWN_IF) begin
                            if_rdata <= mem_rdata;
                        end else if (!cap_we) begin
                            // Write acks carry no data; me_rdata keeps the last load.
                            me_rdata <= mem_rdata;
                        end
                    end
                end
                ST_RESP: begin
                    discard <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_req   = (state == ST_REQ);
    assign mem_we    = cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;

    // A flush coinciding with the response cycle also kills the pulse.
    assign if_rvalid = (state == ST_RESP) && (owner == OWN_IF) && !discard && !if_flush;
    assign me_done   = (state == ST_RESP) && (owner == OWN_ME);

endmodule
